// File: rtl/sync_fifo_buf.sv
// Circular-buffer synchronous FIFO feeding a single-register output stage.
// Ports: clk, rst_n, wr_en/wr_data/full, rd_en/rd_data/rd_valid, empty, count.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky ovf_err/udf_err outputs.
module sync_fifo_buf #(
  parameter int FIFO_WIDTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_W:0]       count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [FIFO_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_ptr_n;
  logic [ADDR_W:0] rd_ptr_n;
  logic [ADDR_W:0] count_n;
  logic            empty_n;
  logic            full_n;
  logic            wr_acc;
  logic            rd_acc;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Flags are derived from the next pointers so that
  // count, empty and full are all registered together.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (wr_acc) wr_ptr_n = wr_ptr + 1'b1;
    if (rd_acc) rd_ptr_n = rd_ptr + 1'b1;
    count_n = wr_ptr_n - rd_ptr_n;
    empty_n = (wr_ptr_n == rd_ptr_n);
    full_n  = (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]) &&
              (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      empty    <= empty_n;
      full     <= full_n;
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  // Storage is not reset; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_en & full)  ovf_err <= 1'b1;
      if (rd_en & empty) udf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/sync_fifo_buf.md
Name: sync_fifo_buf

Overview:
- Circular-buffer synchronous FIFO placed directly upstream of the single-register output stage.
- Absorbs bursty writes and replays them in order. rd_valid and rd_data connect straight to that stage's en and data_i.
- Single clock domain. Registered read data. No fall-through.

Parameters:
- FIFO_WIDTH, 8, data word width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W entries (default 16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_data  input  FIFO_WIDTH  write data.
- full  output  1  high when count == 2**ADDR_W.
- rd_en  input  1  read request.
- rd_data  output  FIFO_WIDTH  registered read data, valid when rd_valid is high.
- rd_valid  output  1  one-cycle strobe marking rd_data as new.
- empty  output  1  high when count == 0.
- count  output  ADDR_W+1  number of stored entries.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All state updates occur on posedge clk.
- Reset (asserted at any time, including mid-burst): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0. Storage array is not reset. Contents are lost and treated as don't-care.
- Pointers are ADDR_W+1 bits. The low ADDR_W bits index storage, and the MSB is the wrap bit.
  - empty when pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2**(ADDR_W+1).
- Write accept: wr_acc = wr_en & ~full. On accept, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en & ~empty. On accept, rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid <= 1 in the next cycle.
- If there is no accepted read, rd_valid <= 0 and rd_data holds its last value.
- Read latency: data appears on rd_data with rd_valid=1 exactly 1 cycle after the accepting edge. Back-to-back reads give a continuous rd_valid stream.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both accept, or when neither does.
- full, empty and count are registered and consistent with each other in every cycle.
- Write while full: dropped, even if a read is accepted in the same cycle. No write-through when full.
- Read while empty: ignored, rd_valid stays 0, even if a write is accepted in the same cycle. No fall-through. The new word is readable from the next cycle.
- Simultaneous accepted read and write when 0 < count < depth: both proceed, count is unchanged. When rd_ptr == wr_ptr low bits, the read returns the old entry.
- Ordering: strict FIFO. No data corruption across pointer wrap.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs ovf_err and udf_err (1 bit each), both reset to 0.
  - ovf_err sets sticky on wr_en & full.
  - udf_err sets sticky on rd_en & empty.
  - Both clear only on reset.
- Undefined: ports and logic are absent. Dropped requests are silent.

Test Plan:
- Reset then idle 5 cycles -> empty=1, full=0, count=0, rd_valid=0, rd_data=0.
- Write 0x01..0x10 (16 words) then wr_en with 0xFF -> full=1 and count=16 after the 16th write; 0xFF dropped; if the macro is defined, ovf_err=1.
- From full, read 16 back-to-back -> rd_valid high 16 consecutive cycles, starting 1 cycle after the first rd_en, with data 0x01..0x10 in order; then empty=1, count=0.
- Fill 8 words, then simultaneous wr/rd for 20 cycles with an incrementing pattern -> count stays 8, pointers wrap, output sequence matches input order.
- Empty FIFO, wr_en=1 (0xA5) and rd_en=1 in the same cycle -> read ignored, rd_valid=0; next cycle rd_en -> rd_data=0xA5, rd_valid=1 one cycle later.
- Assert rst_n=0 asynchronously mid-burst with count=5 -> outputs return to reset values immediately without a clock edge; after release, FIFO behaves as empty.
